gray_dec_rx: RTL

Receive-side companion to the team's Gray-code counters. It samples a Gray-coded count bus driven from another clock domain through a multi-flop synchronizer and decodes it to binary. It reports per-sample progress (a step pulse and a modulo delta) and flags illegal multi-bit transitions. It sits at the destination end of a Gray-count clock-domain crossing, for example a FIFO pointer or an event counter crossing.

---
 rtl/gray_dec_rx.sv | 128 ++++++++++++
 1 files changed

// File: rtl/gray_dec_rx.sv
// Destination-side receiver for a Gray-coded count crossing clock domains:
// synchronizes the bus, decodes it to binary, and reports step/delta/jump.
module gray_dec_rx #(
  parameter int SIZE        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] gray_in,
  input  logic            err_clr,
  output logic [SIZE-1:0] bin,
  output logic            bin_vld,
  output logic            step,
  output logic [SIZE-1:0] delta,
  output logic            jump,
  output logic            err
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t          r_state;
  logic [SIZE-1:0] r_sync [SYNC_STAGES];
  logic [SIZE-1:0] r_g_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [SIZE-1:0] r_bin;
  logic            r_bin_vld;
  logic            r_step;
  logic [SIZE-1:0] r_delta;
  logic            r_jump;
  logic            r_err;

  logic [SIZE-1:0] w_sync_q;
  logic [SIZE-1:0] w_dec;
  logic [SIZE-1:0] w_diff;
  logic            w_move;
  logic            w_multi;

  function automatic logic [SIZE-1:0] gray2bin(input logic [SIZE-1:0] g);
    logic [SIZE-1:0] b;
    b[SIZE-1] = g[SIZE-1];
    for (int i = SIZE - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // NOTE: every synchronizer stage is reset, so a stale pre-reset value can
  // never be decoded during INIT; this is a flop chain, not a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_sync_q = r_sync[SYNC_STAGES-1];
  assign w_dec    = gray2bin(w_sync_q);
  assign w_diff   = w_sync_q ^ r_g_prev;
  assign w_move   = |w_diff;
  // Clearing the lowest set bit leaves something only if two or more bits differ.
  assign w_multi  = |(w_diff & (w_diff - SIZE'(1)));

  // NOTE: all state here uses non-blocking assignments so every register
  // sees the pre-edge values of the others (delta uses the old r_bin).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_INIT;
      r_cnt     <= '0;
      r_g_prev  <= '0;
      r_bin     <= '0;
      r_bin_vld <= 1'b0;
      r_step    <= 1'b0;
      r_delta   <= '0;
      r_jump    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_step <= 1'b0;
      r_jump <= 1'b0;
      case (r_state)
        S_INIT: begin
          if (err_clr) r_err <= 1'b0;
          if (r_cnt == CNT_W'(SYNC_STAGES)) begin
            r_bin     <= w_dec;
            r_g_prev  <= w_sync_q;
            r_bin_vld <= 1'b1;
            r_state   <= S_RUN;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (w_move) begin
            r_bin    <= w_dec;
            r_g_prev <= w_sync_q;
            r_delta  <= w_dec - r_bin;
            r_step   <= 1'b1;
          end
          // A jump sets err even if err_clr is asserted on the same edge.
          if (w_multi) begin
            r_jump <= 1'b1;
            r_err  <= 1'b1;
          end else if (err_clr) begin
            r_err <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bin     = r_bin;
  assign bin_vld = r_bin_vld;
  assign step    = r_step;
  assign delta   = r_delta;
  assign jump    = r_jump;
  assign err     = r_err;

endmodule
